// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and width helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_e;

  localparam int unsigned DEFAULT_DATA_W = 32;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_iter.sv
// Single combinational step: shift-add multiply or restoring shift-subtract divide
// on a {upper, lower} 2*DATA_W accumulator.
module muldiv_iter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  div_mode,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder with the next dividend bit shifted in.
    shifted = acc[2*DATA_W-1:DATA_W-1];
    diff    = shifted - {1'b0, opnd};
    if (div_mode) begin
      if (diff[DATA_W]) begin
        acc_next = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end else begin
        acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end
    end else begin
      acc_next = {sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);
  localparam int unsigned ACC_W = 2 * DATA_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_step, prod_fix;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix;
  logic                neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic                signed_op, sign_a, sign_b, div_mode;
  logic [DATA_W-1:0]   mag_a, mag_b;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = ~op[0];
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign signed_op  = 1'b0;
`endif

  assign sign_a = signed_op & src_a[DATA_W-1];
  assign sign_b = signed_op & src_b[DATA_W-1];
  assign mag_a  = sign_a ? -src_a : src_a;
  assign mag_b  = sign_b ? -src_b : src_b;

  assign div_mode = (state_q == DIV);

  muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .div_mode (div_mode),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  // Sign fix-up applied to the final step's output as it is written into HI/LO.
  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign quo      = acc_step[DATA_W-1:0];
  assign rem      = acc_step[ACC_W-1:DATA_W];
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_rem_q ? -rem : rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dz_d      = 1'b0;
          cnt_d     = CNT_W'(DATA_W);
          if (op[1]) begin
            acc_d  = {{DATA_W{1'b0}}, mag_a};
            opnd_d = mag_b;
            if (src_b == '0) begin
              hi_d    = src_a;
              lo_d    = '1;
              dz_d    = 1'b1;
              state_d = FIN;
            end else begin
              state_d = DIV;
            end
          end else begin
            acc_d   = {{DATA_W{1'b0}}, mag_b};
            opnd_d  = mag_a;
            state_d = MUL;
          end
        end
      end
      MUL, DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
          if (state_q == MUL) begin
            {hi_d, lo_d} = prod_fix;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign done        = (state_q == FIN);
  assign div_by_zero = dz_q && (state_q == FIN);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed vector bench for muldiv_hilo_unit (DATA_W = 32).
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_hilo_unit #(
    .DATA_W (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic mt(input logic h, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    hi_we = h;
    lo_we = l;
    wdata = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  // Waits for done after a start edge already consumed; n counts edges including that one.
  task automatic wait_done(inout int n, output bit seen, output int nbusy);
    seen  = 1'b0;
    nbusy = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit poke);
    int n, nbusy, ndone, lat;
    bit seen;
    lat = v.dz ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    src_a = v.a;
    src_b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    if (busy) nbusy = 1; else nbusy = 0;
    seen = done;
    if (!seen) begin
      int extra;
      if (poke) begin
        // Second start while busy must be dropped.
        @(posedge clk); #1; n++;
        start = 1'b1;
        @(posedge clk); #1; n++;
        start = 1'b0;
        nbusy += 2;
      end
      wait_done(n, seen, extra);
      nbusy += extra;
    end
    check({nm, " done seen"}, 64'(seen), 64'(1));
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " busy cycles"}, 64'(nbusy), 64'(lat - 1));
    check({nm, " busy at done"}, 64'(busy), 64'(0));
    check({nm, " hi"}, 64'(hi), 64'(v.hi));
    check({nm, " lo"}, 64'(lo), 64'(v.lo));
    check({nm, " div_by_zero"}, 64'(div_by_zero), 64'(v.dz));
    @(posedge clk);
    #1;
    check({nm, " done pulse width"}, 64'(done), 64'(0));
    if (poke) begin
      ndone = 0;
      repeat (W + 8) begin
        @(posedge clk);
        #1;
        if (done) ndone++;
      end
      check({nm, " no queued op"}, 64'(ndone), 64'(0));
    end
  endtask

  vec_t vecs[12];

  initial begin
    int n, nbusy;
    bit seen;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[2]  = '{OP_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b0};
    vecs[4]  = '{OP_MULTU, 32'h0,         32'h12345,     32'h0,         32'h0,         1'b0};
    vecs[5]  = '{OP_DIVU,  32'd5,         32'd9,         32'd5,         32'd0,         1'b0};
    vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{OP_MULTU, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0};
`ifdef MULDIV_SIGNED_EN
    vecs[9]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[10] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
`else
    vecs[9]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'h4,         32'hFFFF_FFF1, 1'b0};
    vecs[10] = '{OP_DIV,   32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
    vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset dz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], i == 1);
    end

    // MTHI/MTLO in IDLE, separately and together.
    mt(1'b1, 1'b1, 32'h0F0F);
    check("mt both hi", 64'(hi), 64'h0F0F);
    check("mt both lo", 64'(lo), 64'h0F0F);
    mt(1'b1, 1'b0, 32'hAAAA);
    mt(1'b0, 1'b1, 32'h5555);
    check("mthi", 64'(hi), 64'hAAAA);
    check("mtlo", 64'(lo), 64'h5555);

    // Writes held during busy and FIN must be ignored.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    n = 1;
    repeat (8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy-write hi", 64'(hi), 64'hAAAA);
    check("busy-write lo", 64'(lo), 64'h5555);
    wait_done(n, seen, nbusy);
    check("busy-write done", 64'(seen), 64'(1));
    check("busy-write res hi", 64'(hi), 64'h0);
    check("busy-write res lo", 64'(lo), 64'd12);
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("fin-write hi", 64'(hi), 64'h0);
    check("fin-write lo", 64'(lo), 64'd12);

    // MTLO together with start: write lands, result overwrites at FIN.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; lo_we = 1'b1; wdata = 32'h77;
    @(posedge clk);
    #1;
    start = 1'b0; lo_we = 1'b0;
    check("start+mtlo lo", 64'(lo), 64'h77);
    n = 1;
    wait_done(n, seen, nbusy);
    check("start+mtlo done", 64'(seen), 64'(1));
    check("start+mtlo res lo", 64'(lo), 64'd14);
    check("start+mtlo res hi", 64'(hi), 64'd2);

    // Reset mid-operation aborts without a result.
    mt(1'b1, 1'b1, 32'h1);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'h2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort hi", 64'(hi), 64'h0);
    check("abort lo", 64'(lo), 64'h0);
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (W + 8) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("abort no done", 64'(n), 64'(0));
    run_vec("after abort", vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
